// File: rtl/fix_mul_arbiter_pkg.sv
// Shared fixed-point definitions for the CNN datapath: default format and saturation limits.
// Latency: none (compile-time constants and a constant helper function only).
// Backpressure: not applicable.
package fix_mul_arbiter_pkg;

    // Default Q8.8 datapath format
    localparam int FIX_WIDTH = 16;
    localparam int FIX_POINT = 8;

    // Saturation limits for the default format
    localparam logic [FIX_WIDTH-1:0] FIX_MAX = 16'h7FFF;
    localparam logic [FIX_WIDTH-1:0] FIX_MIN = 16'h8000;

    // Largest positive two's-complement value of a w-bit word (w <= 64)
    function automatic logic [63:0] fix_sat_max(input int w);
        fix_sat_max = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word (w <= 64)
    function automatic logic [63:0] fix_sat_min(input int w);
        fix_sat_min = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fix_mul_pipe.sv
// Signed fixed-point multiplier: full product, arithmetic shift by POINT_WIDTH, saturate to WIDTH.
// Latency: MUL_LAT cycles of enabled clocks; the result register only loads when a valid product arrives.
// Backpressure: en=0 freezes every stage; rst wins over en.
module fix_mul_pipe
    import fix_mul_arbiter_pkg::*;
#(
    parameter int WIDTH       = FIX_WIDTH,
    parameter int POINT_WIDTH = FIX_POINT,
    parameter int MUL_LAT     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             last_load,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out_p
);

    // Use the shared constants when the format matches the datapath default
    localparam logic [WIDTH-1:0] SAT_MAX = (WIDTH == FIX_WIDTH) ? WIDTH'(FIX_MAX)
                                                                : WIDTH'(fix_sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = (WIDTH == FIX_WIDTH) ? WIDTH'(FIX_MIN)
                                                                : WIDTH'(fix_sat_min(WIDTH));

    // Full-precision multiply, floor shift, and clamp when the dropped high bits
    // are not a sign extension of the kept MSB.
    function automatic logic [WIDTH-1:0] sat_mul(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0]       full;
        logic [WIDTH-POINT_WIDTH:0] upper;
        full  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        upper = full[2*WIDTH-1 : WIDTH+POINT_WIDTH-1];
        if ((&upper) || (~|upper)) begin
            sat_mul = full[WIDTH+POINT_WIDTH-1 : POINT_WIDTH];
        end else if (full[2*WIDTH-1]) begin
            sat_mul = SAT_MIN;
        end else begin
            sat_mul = SAT_MAX;
        end
    endfunction

    generate
        if (MUL_LAT == 1) begin : g_lat1
            // Single stage: multiply straight from the granted operands into the result register
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_p <= '0;
                end else if (en && last_load) begin
                    out_p <= sat_mul(in_a, in_b);
                end
            end
        end else begin : g_latn
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] res_q [2:MUL_LAT];

            // Stage 1 registers operands, stage 2 holds the saturated product, later stages delay it;
            // the final stage only loads valid data so the output holds its last result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    for (int k = 2; k <= MUL_LAT; k++) begin
                        res_q[k] <= '0;
                    end
                end else if (en) begin
                    a_q <= in_a;
                    b_q <= in_b;
                    if ((MUL_LAT > 2) || last_load) begin
                        res_q[2] <= sat_mul(a_q, b_q);
                    end
                    for (int k = 3; k <= MUL_LAT; k++) begin
                        if ((k < MUL_LAT) || last_load) begin
                            res_q[k] <= res_q[k-1];
                        end
                    end
                end
            end

            assign out_p = res_q[MUL_LAT];
        end
    endgenerate

endmodule

// File: rtl/fix_mul_arbiter.sv
// Round-robin arbiter sharing one saturating fixed-point multiplier among N_REQ requesters.
// Latency: result MUL_LAT non-held cycles after the grant, one grant per cycle, in grant order.
// Backpressure: hold freezes grants, pipeline, pointer and outputs; req_ready is zero during hold or rst.
module fix_mul_arbiter
    import fix_mul_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = FIX_WIDTH,
    parameter int POINT_WIDTH = FIX_POINT,
    parameter int MUL_LAT     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   hold,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_p,
    output logic                   busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Valid/tag pipeline; stage k holds the transaction granted k enabled cycles ago
    logic [MUL_LAT:1] vld_q;
    logic [PTR_W-1:0] tag_q [1:MUL_LAT];
    logic [MUL_LAT:0] stg_vld;

    // Round-robin search starting at rr_ptr; no grant while held or in reset
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        if (!rst && !hold) begin
            for (int off = 0; off < N_REQ; off++) begin
                idx = int'(rr_ptr) + off;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                cand = PTR_W'(idx);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // One-hot ready to the winner only
    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];

    // Stage 0 is the current-cycle grant, which feeds stage 1
    assign stg_vld = {vld_q, grant_any};

    // Advance pointer and valid/tag pipeline on every non-held cycle; reset discards in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            vld_q  <= '0;
            for (int k = 1; k <= MUL_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else if (!hold) begin
            vld_q    <= stg_vld[MUL_LAT-1:0];
            tag_q[1] <= grant_idx;
            for (int k = 2; k <= MUL_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            if (grant_any) begin
                rr_ptr <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Response owner is decoded from the last-stage tag
    always_comb begin
        rsp_valid = '0;
        if (vld_q[MUL_LAT]) begin
            rsp_valid[tag_q[MUL_LAT]] = 1'b1;
        end
    end

    // Anything registered in the pipeline counts; the current grant does not
    assign busy = |vld_q;

    fix_mul_pipe #(
        .WIDTH       (WIDTH),
        .POINT_WIDTH (POINT_WIDTH),
        .MUL_LAT     (MUL_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (~hold),
        .last_load (stg_vld[MUL_LAT-1]),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .out_p     (rsp_p)
    );

endmodule

// File: tb/tb_fix_mul_arbiter.sv
// Self-checking bench for fix_mul_arbiter with a transaction-level reference model.
// Latency: model expects each product MUL_LAT non-held cycles after its grant.
// Backpressure: random hold and reset are applied alongside directed cases.
module tb_fix_mul_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int LAT = 3;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           hold;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_p;
    logic           busy;

    fix_mul_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .hold      (hold),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [15:0] p;
        int          due;
    } item_t;

    item_t       q[$];
    int          ptr;
    int          tick;
    logic [15:0] last_p;
    int          errors;
    int          checks;

    logic [N-1:0] obs_rdy;
    logic [N-1:0] obs_rv;
    logic [W-1:0] obs_p;
    logic         obs_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference product: exact integer product, floor division by 256, clamp to 16-bit range
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        longint pa;
        longint s;
        pa = longint'($signed(a)) * longint'($signed(b));
        s  = pa >>> 8;
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 1) == 1) v = {{6{v[9]}}, v[9:0]};
        return v;
    endfunction

    // One clock cycle: check outputs against the model mid-cycle, then advance the model
    task automatic step();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        int           gidx;
        item_t        it;
        exp_rdy = '0;
        exp_rv  = '0;
        gidx    = -1;
        @(negedge clk);
        if (!rst && !hold) begin
            for (int o = 0; o < N; o++) begin
                int i;
                i = (ptr + o) % N;
                if (gidx < 0 && req_valid[i]) gidx = i;
            end
        end
        if (gidx >= 0) exp_rdy[gidx] = 1'b1;
        check("ready", req_ready, exp_rdy);
        if (!rst) begin
            if (q.size() > 0 && q[0].due == tick) exp_rv[q[0].tag] = 1'b1;
            check("busy", busy, (q.size() > 0));
            check("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != 0) check("rsp_p", rsp_p, q[0].p);
            else             check("rsp_p_hold", rsp_p, last_p);
        end
        obs_rdy  = req_ready;
        obs_rv   = rsp_valid;
        obs_p    = rsp_p;
        obs_busy = busy;
        if (gidx >= 0) begin
            it.tag = gidx;
            it.p   = ref_mul(req_a[gidx*W +: W], req_b[gidx*W +: W]);
            it.due = tick + LAT;
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            ptr    = 0;
            last_p = '0;
        end else if (!hold) begin
            if (exp_rv != 0) begin
                last_p = q[0].p;
                void'(q.pop_front());
            end
            if (gidx >= 0) begin
                q.push_back(it);
                ptr = (gidx + 1) % N;
            end
            tick++;
        end
        #1;
    endtask

    task automatic single(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input int hold_cyc);
        int n;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        step();
        check("sgl_grant", obs_rdy, 1 << idx);
        req_valid = '0;
        for (int h = 0; h < hold_cyc; h++) begin
            hold = 1'b1;
            req_valid = '1;
            step();
            check("hold_nogrant", obs_rdy, 0);
        end
        hold = 1'b0;
        req_valid = '0;
        n = hold_cyc;
        do begin
            n++;
            step();
        end while (obs_rv == 0 && n < 20);
        check("sgl_latency", n, 3 + hold_cyc);
        check("sgl_value", obs_p, exp);
        check("sgl_owner", obs_rv, 1 << idx);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        ptr       = 0;
        tick      = 0;
        last_p    = '0;
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;

        // Reset: ready must stay low even with every requester valid
        step();
        step();
        rst = 1'b0;
        req_valid = '0;
        step();
        check("rst_busy", obs_busy, 0);
        check("rst_rsp_p", obs_p, 0);

        // Directed arithmetic cases
        single(0, 16'h0100, 16'h0100, 16'h0100, 0);
        single(1, 16'hFE80, 16'h0200, 16'hFD00, 0);
        single(2, 16'h0001, 16'hFFFF, 16'hFFFF, 0);
        single(3, 16'h7F00, 16'h0200, 16'h7FFF, 0);
        single(0, 16'h8000, 16'h0200, 16'h8000, 0);

        // Hold right after the grant delays the response by two cycles
        single(2, 16'h0180, 16'h0300, 16'h0480, 2);

        // Contention from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 4) ? '1 : '0;
            for (int r = 0; r < N; r++) begin
                req_a[r*W +: W] = rand_op();
                req_b[r*W +: W] = rand_op();
            end
            step();
            check("cont_grant", obs_rdy, (c < 4) ? (1 << c) : 0);
            if (c >= 3) check("cont_rsp", obs_rv, 1 << (c - 3));
        end

        // Reset one cycle after two grants discards them and restarts the pointer
        req_valid = 4'b0011;
        step();
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("midrst_busy", obs_busy, 0);
        for (int c = 0; c < 5; c++) begin
            step();
            check("midrst_norsp", obs_rv, 0);
        end
        req_valid = '1;
        step();
        check("midrst_ptr", obs_rdy, 1);
        req_valid = '0;
        for (int c = 0; c < 6; c++) step();

        // Randomized traffic with occasional hold and reset
        for (int c = 0; c < 600; c++) begin
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) begin
                req_a[r*W +: W] = rand_op();
                req_b[r*W +: W] = rand_op();
            end
            hold = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end
        rst       = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 10; c++) step();
        check("drain_busy", obs_busy, 0);
        check("drain_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fix_mul_arbiter.md
FIX_MUL_ARBITER -- requirements
Module: fix_mul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one multiplier.
REQ-002 SHALL have parameter WIDTH, default 16: total fixed-point width, two's complement.
REQ-003 SHALL have parameter POINT_WIDTH, default 8: fractional bits.
REQ-004 SHALL have parameter MUL_LAT, default 3: multiplier pipeline depth in cycles, legal range 1..8.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, N_REQ: per-requester operand valid.
REQ-008 SHALL have port req_a, input, N_REQ*WIDTH: operand A, requester i in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_b, input, N_REQ*WIDTH: operand B, same packing.
REQ-010 SHALL have port req_ready, output, N_REQ: one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-011 SHALL have port hold, input, 1: freeze grants and the pipeline.
REQ-012 SHALL have port rsp_valid, output, N_REQ: one-hot; marks the owner of rsp_p.
REQ-013 SHALL have port rsp_p, output, WIDTH: saturated fixed-point product.
REQ-014 SHALL have port busy, output, 1: high while any product is in flight.

Function
REQ-015 SHALL grant at most one requester per cycle, round-robin, starting the search at pointer rr_ptr.
REQ-016 SHALL drive req_ready combinationally from req_valid, rr_ptr and hold; req_ready SHALL be all-zero when hold=1.
REQ-017 SHALL set rr_ptr to (granted index + 1) mod N_REQ on each grant; with no grant, rr_ptr SHALL remain unchanged.
REQ-018 SHALL capture the granted operands and a tag (granted index) into stage 1 of a MUL_LAT-deep valid/tag pipeline.
REQ-019 SHALL form the full 2*WIDTH signed product and select bits [WIDTH+POINT_WIDTH-1 : POINT_WIDTH], truncating toward negative infinity.
REQ-020 SHALL saturate to 0x7FFF (positive overflow) or 0x8000 (negative overflow) for WIDTH=16 whenever the discarded high bits are not a sign extension of the result MSB.
REQ-021 SHALL assert rsp_valid[tag] exactly MUL_LAT non-held cycles after the grant, for exactly one cycle, with rsp_p valid in that cycle.
REQ-022 SHALL drive rsp_valid all-zero and hold rsp_p at its last value when no result is valid.
REQ-023 SHALL freeze all pipeline stages, valid/tag bits, rr_ptr and outputs while hold=1; it SHALL neither drop nor duplicate results.
REQ-024 SHALL sustain one grant per cycle when several requesters are continuously valid (throughput 1 per cycle).
REQ-025 SHALL keep busy high while any pipeline valid bit is set; busy SHALL ignore the current-cycle grant.
REQ-026 SHALL deliver results in grant order; no reordering between requesters.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear rr_ptr to 0, all pipeline valid bits, rsp_valid, rsp_p and busy to 0.
REQ-028 SHALL discard in-flight products when reset is asserted mid-operation; no rsp_valid SHALL be asserted for them afterwards.
REQ-029 SHALL drive req_ready all-zero while rst=1.
REQ-030 SHALL give rst priority over hold.

Structure
REQ-031 SHALL take default WIDTH, POINT_WIDTH and the saturation constants (max/min) from the shared fixed-point package used by the CNN datapath.
REQ-032 SHALL instantiate one sub-module, fix_mul_pipe: the MUL_LAT-stage signed multiply with shift and saturate, with an enable input driven by ~hold.
REQ-033 SHALL keep the round-robin arbiter and the tag/valid pipeline in fix_mul_arbiter itself.

Verification
REQ-034 SHALL cover single request: req 0, A=0x0100, B=0x0100 -> rsp_valid=0001, rsp_p=0x0100 exactly 3 cycles after the grant.
REQ-035 SHALL cover signed and truncation cases:
- A=0xFE80 (-1.5), B=0x0200 (2.0) -> 0xFD00.
- A=0x0001, B=0xFFFF -> 0xFFFF.
REQ-036 SHALL cover saturation:
- A=0x7F00, B=0x0200 -> 0x7FFF.
- A=0x8000, B=0x0200 -> 0x8000.
REQ-037 SHALL cover contention: all 4 requesters valid from cycle 0 -> grants 0,1,2,3 in cycles 0..3; rsp_valid 0001, 0010, 0100, 1000 in cycles 3..6.
REQ-038 SHALL cover hold: hold=1 for 2 cycles right after a grant -> response delayed by exactly 2 cycles, value unchanged, no grant during hold.
REQ-039 SHALL cover reset mid-operation: rst=1 one cycle after 2 grants -> no rsp_valid afterwards, busy=0, and rr_ptr restarts at requester 0.
